instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Wishbone instruction fetcher feeding a FIFO_DEPTH-entry buffer; push to instr_valid_o is one cycle.
// Requests stop while the buffer is full or after a fault until redirect; ECPU_FETCH_PERF_EN adds perf_fetch_cnt_o.

module ifu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Flush drops the contents by resetting pointers; stale storage is hidden by count == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o,
  input  logic        instr_ready_i
`ifdef ECPU_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_FULL, S_HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [CW-1:0] count;
  logic          req;
  logic          push;
  logic          pop;
  entry_t        push_ent;
  entry_t        head_ent;

  // Gating with rst_ni drops the request the moment reset asserts.
  assign req  = rst_ni && (state == S_RUN) && (count < DEPTH_C);
  assign push = req && (ack_i || err_i) && !redirect_i;
  assign pop  = (count != '0) && instr_ready_i && !redirect_i;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    push_ent.instr = dat_i;
    push_ent.pc    = fetch_pc;
    push_ent.err   = 1'b0;
    case (state)
      S_RUN: begin
        if (push && err_i) begin
          state_nxt = S_HALT;
        end else if (push && !pop && (count == DEPTH_C - 1'b1)) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (pop) state_nxt = S_RUN;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: state_nxt = S_RUN;
    endcase
    // A fault wins over a simultaneous ack and keeps the PC pointing at the faulting address.
    if (push) begin
      if (err_i) begin
        push_ent.instr = '0;
        push_ent.err   = 1'b1;
      end else begin
        fetch_pc_nxt = fetch_pc + 32'd4;
      end
    end
    if (redirect_i) begin
      state_nxt    = S_RUN;
      fetch_pc_nxt = redirect_pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  ifu_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (redirect_i),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (count)
  );

  assign cyc_o         = req;
  assign stb_o         = req;
  assign we_o          = 1'b0;
  assign sel_o         = 4'hF;
  assign adr_o         = fetch_pc;
  assign instr_valid_o = (count != '0);
  assign instr_o       = head_ent.instr;
  assign instr_pc_o    = head_ent.pc;
  assign instr_err_o   = head_ent.err;

`ifdef ECPU_FETCH_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cnt <= '0;
    end else if (push && !err_i) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_cnt;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset corners, and random traffic
// checked against a stream-order scoreboard of the fetch program.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          FD  = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o, instr_pc_o;
  logic        instr_err_o;
  logic        instr_ready_i = 1'b0;
  logic        ack_en = 1'b1;
`ifdef ECPU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] init_words [4];

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a < 32'd16) return init_words[a[3:2]];
    return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
  endfunction

  // Instruction memory: combinational response, faults on misaligned addresses.
  assign dat_i = memw(adr_o);
  assign ack_i = stb_o && ack_en && (adr_o[1:0] == 2'b00);
  assign err_i = stb_o && ack_en && (adr_o[1:0] != 2'b00);

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(FD)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .we_o          (we_o),
    .adr_o         (adr_o),
    .sel_o         (sel_o),
    .dat_i         (dat_i),
    .ack_i         (ack_i),
    .err_i         (err_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_err_o   (instr_err_o),
    .instr_ready_i (instr_ready_i)
`ifdef ECPU_FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_err;
    logic        e_stb;
    logic [31:0] e_adr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rp,
                              input logic v, input logic [31:0] ins, input logic [31:0] pc,
                              input logic er, input logic stb, input logic [31:0] adr);
    vec_t t;
    t.ready = rdy; t.redir = rd; t.rpc = rp;
    t.e_valid = v; t.e_instr = ins; t.e_pc = pc; t.e_err = er;
    t.e_stb = stb; t.e_adr = adr;
    return t;
  endfunction

  vec_t vt [26];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        q [$];
  logic [31:0] mpc;
  bit          halted;
  int          ok_fetches;

  task automatic rand_phase(input int ncyc);
    exp_t        e;
    logic        m_stb;
    logic [31:0] tgt;
    int          r;
    do_reset();
    q.delete();
    mpc = RPC;
    halted = 1'b0;
    ok_fetches = 0;
    for (int c = 0; c < ncyc; c++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      ack_en = ($urandom_range(0, 4) != 0);
      redirect_i = ($urandom_range(0, 24) == 0) || (halted && $urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      tgt = $urandom & 32'h0000_0FFC;
      if (r == 0) tgt = tgt | 32'h2;
      else if (r == 1) tgt = 32'hFFFF_FFF0;
      redirect_pc_i = tgt;
      #1;
      m_stb = !halted && (q.size() < FD);
      chk("rnd_valid", instr_valid_o, q.size() != 0);
      chk("rnd_stb", stb_o, m_stb);
      chk("rnd_cyc", cyc_o, m_stb);
      chk("rnd_adr", adr_o, mpc);
      if (q.size() != 0) begin
        chk("rnd_instr", instr_o, q[0].instr);
        chk("rnd_pc", instr_pc_o, q[0].pc);
        chk("rnd_err", instr_err_o, q[0].err);
      end
      if (redirect_i) begin
        q.delete();
        mpc = tgt;
        halted = 1'b0;
      end else begin
        if (q.size() != 0 && instr_ready_i) void'(q.pop_front());
        if (m_stb && ack_en) begin
          e.pc = mpc;
          if (mpc[1:0] != 2'b00) begin
            e.instr = 32'h0;
            e.err = 1'b1;
            halted = 1'b1;
          end else begin
            e.instr = memw(mpc);
            e.err = 1'b0;
            mpc = mpc + 32'd4;
            ok_fetches++;
          end
          q.push_back(e);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    redirect_i = 1'b0;
`ifdef ECPU_FETCH_PERF_EN
    #1;
    chk("rnd_perf", perf_fetch_cnt_o, ok_fetches);
`endif
  endtask

  initial begin
    init_words[0] = 32'd13;
    init_words[1] = 32'd93;
    init_words[2] = 32'd113;
    init_words[3] = 32'd193;

    vt[0]  = mk(1, 0, 0,            0, 0,            0,            0, 1, 32'h0);
    vt[1]  = mk(1, 0, 0,            1, 32'd13,       32'h0,        0, 1, 32'h4);
    vt[2]  = mk(1, 0, 0,            1, 32'd93,       32'h4,        0, 1, 32'h8);
    vt[3]  = mk(1, 0, 0,            1, 32'd113,      32'h8,        0, 1, 32'hC);
    vt[4]  = mk(1, 0, 0,            1, 32'd193,      32'hC,        0, 1, 32'h10);
    vt[5]  = mk(0, 0, 0,            1, 32'hC0DE0010, 32'h10,       0, 1, 32'h14);
    vt[6]  = mk(0, 0, 0,            1, 32'hC0DE0010, 32'h10,       0, 0, 32'h18);
    vt[7]  = mk(0, 0, 0,            1, 32'hC0DE0010, 32'h10,       0, 0, 32'h18);
    vt[8]  = mk(0, 0, 0,            1, 32'hC0DE0010, 32'h10,       0, 0, 32'h18);
    vt[9]  = mk(0, 0, 0,            1, 32'hC0DE0010, 32'h10,       0, 0, 32'h18);
    vt[10] = mk(1, 0, 0,            1, 32'hC0DE0010, 32'h10,       0, 0, 32'h18);
    vt[11] = mk(1, 0, 0,            1, 32'hC0DE0014, 32'h14,       0, 1, 32'h18);
    vt[12] = mk(0, 0, 0,            1, 32'hC0DE0018, 32'h18,       0, 1, 32'h1C);
    vt[13] = mk(1, 1, 32'h100,      1, 32'hC0DE0018, 32'h18,       0, 0, 32'h20);
    vt[14] = mk(1, 0, 0,            0, 0,            0,            0, 1, 32'h100);
    vt[15] = mk(1, 0, 0,            1, 32'hC0DE0100, 32'h100,      0, 1, 32'h104);
    vt[16] = mk(1, 1, 32'h102,      1, 32'hC0DE0104, 32'h104,      0, 1, 32'h108);
    vt[17] = mk(0, 0, 0,            0, 0,            0,            0, 1, 32'h102);
    vt[18] = mk(0, 0, 0,            1, 32'h0,        32'h102,      1, 0, 32'h102);
    vt[19] = mk(1, 0, 0,            1, 32'h0,        32'h102,      1, 0, 32'h102);
    vt[20] = mk(1, 0, 0,            0, 0,            0,            0, 0, 32'h102);
    vt[21] = mk(1, 1, 32'hFFFFFFF8, 0, 0,            0,            0, 0, 32'h102);
    vt[22] = mk(1, 0, 0,            0, 0,            0,            0, 1, 32'hFFFFFFF8);
    vt[23] = mk(1, 0, 0,            1, 32'hC0DEFFF8, 32'hFFFFFFF8, 0, 1, 32'hFFFFFFFC);
    vt[24] = mk(1, 0, 0,            1, 32'hC0DEFFFC, 32'hFFFFFFFC, 0, 1, 32'h0);
    vt[25] = mk(1, 0, 0,            1, 32'd13,       32'h0,        0, 1, 32'h4);

    // Reset state while rst_ni is held low.
    #1 rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cyc", cyc_o, 1'b0);
    chk("rst_stb", stb_o, 1'b0);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_err", instr_err_o, 1'b0);
    chk("rst_adr", adr_o, RPC);
    chk("we", we_o, 1'b0);
    chk("sel", sel_o, 4'hF);
    rst_ni = 1'b1;

    // Directed table: stream, backpressure, redirect, fault/halt, PC wrap.
    for (int i = 0; i < 26; i++) begin
      instr_ready_i = vt[i].ready;
      redirect_i = vt[i].redir;
      redirect_pc_i = vt[i].rpc;
      #1;
      chk($sformatf("vec%0d_valid", i), instr_valid_o, vt[i].e_valid);
      chk($sformatf("vec%0d_stb", i), stb_o, vt[i].e_stb);
      chk($sformatf("vec%0d_cyc", i), cyc_o, vt[i].e_stb);
      chk($sformatf("vec%0d_adr", i), adr_o, vt[i].e_adr);
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_instr", i), instr_o, vt[i].e_instr);
        chk($sformatf("vec%0d_pc", i), instr_pc_o, vt[i].e_pc);
        chk($sformatf("vec%0d_err", i), instr_err_o, vt[i].e_err);
      end
      @(posedge clk);
      @(negedge clk);
    end
    redirect_i = 1'b0;

    // Reset mid-operation drops the request at once and leaves nothing behind.
    instr_ready_i = 1'b1;
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("midrst_stb", stb_o, 1'b0);
    chk("midrst_valid", instr_valid_o, 1'b0);
    chk("midrst_instr", instr_o, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_stb", stb_o, 1'b1);
    chk("post_rst_adr", adr_o, RPC);
    chk("post_rst_valid", instr_valid_o, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_first_valid", instr_valid_o, 1'b1);
    chk("post_rst_first_pc", instr_pc_o, RPC);
    chk("post_rst_first_instr", instr_o, 32'd13);

`ifdef ECPU_FETCH_PERF_EN
    begin
      int n;
      n = 0;
      do_reset();
      instr_ready_i = 1'b1;
      for (int c = 0; c < 100 && n < 10; c++) begin
        #1;
        if (stb_o && ack_i) n++;
        @(posedge clk);
        @(negedge clk);
      end
      chk("perf_fetches_seen", n, 10);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h2;
      @(posedge clk);
      @(negedge clk);
      redirect_i = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("perf_cnt", perf_fetch_cnt_o, 32'd10);
    end
`endif

    rand_phase(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
